// File: rtl/conv_row_controller.sv
// Row sequencer for the 1-D convolution datapath: FIFO->scratchpad loads, window MAC issue, psum push.
// Optional macro CONV_FILTER_REUSE_EN lets a row skip the filter load when reuse_filter is set at start.
module conv_row_controller #(
  parameter int IF_LEN      = 16,
  parameter int FILTER_SIZE = 4,
  parameter int STRIDE      = 2,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              reuse_filter,
  input  logic              if_empty,
  input  logic              filter_empty,
  input  logic              out_full,
  output logic              if_buf_ren,
  output logic              if_wen,
  output logic [ADDR_W-1:0] if_waddr,
  output logic              filter_buf_ren,
  output logic              filter_wen,
  output logic [ADDR_W-1:0] filter_waddr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] if_raddr,
  output logic [ADDR_W-1:0] filter_raddr,
  output logic              mac_en,
  output logic              psum_clr,
  output logic              out_wen,
  output logic              busy,
  output logic              done
);

  localparam int WINDOWS = (IF_LEN - FILTER_SIZE) / STRIDE + 1;
  localparam int CW      = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] IF_LAST   = ADDR_W'(IF_LEN - 1);
  localparam logic [ADDR_W-1:0] FILT_LAST = ADDR_W'(FILTER_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_IF, LOAD_FILT, COMPUTE, WRITE_OUT, FINISH
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]     pop_cnt;
  logic [CW-1:0]     k_cnt;
  logic [CW-1:0]     win_cnt;
  logic [ADDR_W-1:0] offset;
  logic              reuse_q;

`ifdef CONV_FILTER_REUSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reuse_q <= 1'b0;
    end else if (state == IDLE && start) begin
      reuse_q <= reuse_filter;
    end
  end
`else
  logic unused_reuse;
  assign reuse_q      = 1'b0;
  assign unused_reuse = reuse_filter;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt      = state;
    if_buf_ren     = 1'b0;
    filter_buf_ren = 1'b0;
    rd_en          = 1'b0;
    if_raddr       = '0;
    filter_raddr   = '0;
    out_wen        = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD_IF;
      end
      LOAD_IF: begin
        // The final pop counts only when it really happens, so empty blocks it too.
        if_buf_ren = !if_empty && (pop_cnt < CW'(IF_LEN));
        if (if_wen && if_waddr == IF_LAST) state_nxt = reuse_q ? COMPUTE : LOAD_FILT;
      end
      LOAD_FILT: begin
        filter_buf_ren = !filter_empty && (pop_cnt < CW'(FILTER_SIZE));
        if (filter_wen && filter_waddr == FILT_LAST) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        if (k_cnt < CW'(FILTER_SIZE)) begin
          rd_en        = 1'b1;
          if_raddr     = offset + k_cnt[ADDR_W-1:0];
          filter_raddr = k_cnt[ADDR_W-1:0];
        end else begin
          state_nxt = WRITE_OUT;
        end
      end
      WRITE_OUT: begin
        if (!out_full) begin
          out_wen   = 1'b1;
          state_nxt = (win_cnt == CW'(WINDOWS - 1)) ? FINISH : COMPUTE;
        end
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      if_wen       <= 1'b0;
      filter_wen   <= 1'b0;
      if_waddr     <= '0;
      filter_waddr <= '0;
      mac_en       <= 1'b0;
      psum_clr     <= 1'b0;
      pop_cnt      <= '0;
      k_cnt        <= '0;
      win_cnt      <= '0;
      offset       <= '0;
    end else begin
      state      <= state_nxt;
      // FIFO data lands one cycle after the pop; read data one cycle after rd_en.
      if_wen     <= if_buf_ren;
      filter_wen <= filter_buf_ren;
      mac_en     <= rd_en;
      psum_clr   <= rd_en && (k_cnt == '0);
      case (state)
        IDLE: begin
          if (start) begin
            pop_cnt      <= '0;
            k_cnt        <= '0;
            win_cnt      <= '0;
            offset       <= '0;
            if_waddr     <= '0;
            filter_waddr <= '0;
          end
        end
        LOAD_IF: begin
          if (if_buf_ren) pop_cnt <= pop_cnt + 1'b1;
          if (if_wen && if_waddr != IF_LAST) if_waddr <= if_waddr + 1'b1;
          if (state_nxt != LOAD_IF) pop_cnt <= '0;
        end
        LOAD_FILT: begin
          if (filter_buf_ren) pop_cnt <= pop_cnt + 1'b1;
          if (filter_wen && filter_waddr != FILT_LAST) filter_waddr <= filter_waddr + 1'b1;
          if (state_nxt != LOAD_FILT) pop_cnt <= '0;
        end
        COMPUTE: begin
          if (rd_en) k_cnt <= k_cnt + 1'b1;
          else       k_cnt <= '0;
        end
        WRITE_OUT: begin
          if (out_wen) begin
            win_cnt <= win_cnt + 1'b1;
            offset  <= offset + ADDR_W'(STRIDE);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
